serial_xfer_ctrl: RTL and testbench
===================================

# serial_xfer_ctrl

Controller that sequences the team's shift-register datapath for a framed serial link: it accepts parallel words over a valid/ready handshake, loads and shifts them out MSB-first with a frame strobe, and on the receive side collects framed serial bits back into parallel words. It sits between a parallel producer/consumer and the serial pins (or a loopback), owning all load/shift sequencing, bit counting and framing, so upstream logic never drives shift-register mode controls directly.

## Interface
- WIDTH, 4, word length in bits (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears all state
- tx_data  in  WIDTH  parallel word to transmit
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller can accept a word
- tx_so  out  1  serial data out, MSB first
- tx_frame  out  1  high while tx_so carries a valid bit
- rx_si  in  1  serial data in
- rx_frame  in  1  high while rx_si carries a valid bit
- rx_data  out  WIDTH  last complete received word
- rx_valid  out  1  one-cycle pulse: rx_data updated
- rx_err  out  1  one-cycle pulse: frame ended mid-word

## Operation
- TX FSM states: IDLE, SHIFT, GAP.
- IDLE: tx_ready=1. tx_valid&&tx_ready at an edge → capture tx_data into tx shift reg, load bit counter with WIDTH-1, go SHIFT.
- SHIFT: tx_frame=1, tx_so=shift reg MSB; each edge shift left (0 fill), decrement counter; edge with counter==0 → GAP.
- GAP: tx_frame=0, tx_so=0, tx_ready=0 for one cycle → IDLE.
- tx_ready = (state==IDLE); tx_data ignored outside the handshake edge; tx_valid may drop without acceptance (no side effect).
- RX: each edge with rx_frame=1 shifts rx_si into rx shift reg LSB, increments rx count. On the WIDTH-th bit: rx_data ← assembled word (including this bit), rx_valid=1 next cycle, count → 0. Frames longer than WIDTH yield consecutive words (2·WIDTH bits → two rx_valid pulses, WIDTH cycles apart).
- Edge with rx_frame=0 and count≠0: discard partial word, count → 0, rx_err=1 next cycle; rx_data unchanged.
- RX and TX are independent; tx_so→rx_si, tx_frame→rx_frame loopback returns each transmitted word on rx_data.
- No rx back-pressure: consumer must take rx_data on the rx_valid cycle (rx_data holds until the next word anyway).

## Timing
- Reset values (first cycle after reset edge): state IDLE, tx_ready=1, tx_so=0, tx_frame=0, rx_data=0, rx_valid=0, rx_err=0, both counters 0.
- Handshake at edge N → tx_frame=1 in cycles N+1…N+WIDTH, tx_so=tx_data[WIDTH-1-k] in cycle N+1+k; GAP at N+WIDTH+1; tx_ready=1 again from N+WIDTH+2. Word period WIDTH+2 cycles.
- tx_so, tx_frame, rx_data, rx_valid, rx_err are registered outputs; tx_ready combinational from state only (no path from tx_valid).
- Loopback latency: last bit sampled at edge N+WIDTH+1 → rx_valid high in cycle N+WIDTH+1 (registered) with matching rx_data.
- Reset mid-transfer: TX aborts, tx_frame=0 next cycle, partial RX word discarded with no rx_valid and no rx_err.
- rx_valid and rx_err never assert in the same cycle.

## Structure
- Package serial_xfer_pkg: TX state enum (IDLE, SHIFT, GAP) and default WIDTH constant.
- Sub-module shift_cnt: loadable up/down bit counter with terminal-count flag, counter width $clog2(WIDTH); instantiated once for TX (down) and once for RX (up).
- Shift registers and FSM live in serial_xfer_ctrl.

## Test plan
- Reset then idle: tx_ready=1, tx_frame=0, tx_so=0, rx_valid=0, rx_data=0 for 10 cycles.
- tx_data=4'b1011, tx_valid one cycle: tx_frame high 4 cycles, tx_so sequence 1,0,1,1, tx_ready low 5 cycles (4 SHIFT + GAP).
- Loopback, back-to-back words 4'hA, 4'h5, 4'hF with tx_valid held: rx_valid pulses three times, rx_data = A, 5, F; period 6 cycles.
- rx_frame high 2 cycles (bits 1,1) then low: rx_err pulse one cycle, no rx_valid, rx_data unchanged.
- rx_frame high 8 cycles, bits 1,0,0,1,0,1,1,0: two rx_valid pulses, rx_data 4'h9 then 4'h6.
- Reset asserted at 2nd SHIFT cycle of 4'hC: tx_frame=0 next cycle, tx_ready=1 after reset, no rx_valid/rx_err in loopback.

Source files
------------

// File: rtl/serial_xfer_pkg.sv
// Shared types and constants for the framed serial transfer controller.
package serial_xfer_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } tx_state_e;

endpackage

// File: rtl/shift_cnt.sv
// Loadable up/down bit counter with a terminal-count flag.
// Priority per edge: clr, then load, then en.
module shift_cnt #(
    parameter int unsigned     Width   = 2,
    parameter bit              CountUp = 1'b0,
    parameter logic [Width-1:0] TermVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             tc
);

    logic [Width-1:0] cnt_q;

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= CountUp ? cnt_q + Width'(1) : cnt_q - Width'(1);
        end
    end

    assign count = cnt_q;
    assign tc    = (cnt_q == TermVal);

endmodule

// File: rtl/serial_xfer_ctrl.sv
// Framed serial link controller: parallel-to-serial TX with a one-cycle
// inter-word gap, and serial-to-parallel RX with partial-frame error reporting.
module serial_xfer_ctrl
    import serial_xfer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_so,
    output logic             tx_frame,
    input  logic             rx_si,
    input  logic             rx_frame,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             rx_err
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    // TX side
    tx_state_e        state_q, state_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic             tx_frame_q, tx_frame_d;
    logic             tx_cnt_load, tx_cnt_en, tx_tc;
    logic [CntW-1:0]  tx_cnt;

    // RX side; only WIDTH-1 bits need storing, the last bit comes from rx_si
    logic [WIDTH-2:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d, rx_word;
    logic             rx_valid_q, rx_valid_d;
    logic             rx_err_q, rx_err_d;
    logic             rx_cnt_clr, rx_cnt_en, rx_tc;
    logic [CntW-1:0]  rx_cnt;

    shift_cnt #(
        .Width   (CntW),
        .CountUp (1'b0),
        .TermVal ('0)
    ) u_tx_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (1'b0),
        .load     (tx_cnt_load),
        .load_val (LastIdx),
        .en       (tx_cnt_en),
        .count    (tx_cnt),
        .tc       (tx_tc)
    );

    shift_cnt #(
        .Width   (CntW),
        .CountUp (1'b1),
        .TermVal (LastIdx)
    ) u_rx_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (rx_cnt_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (rx_cnt_en),
        .count    (rx_cnt),
        .tc       (rx_tc)
    );

    // TX next-state: accept in idle, shift WIDTH bits, then one gap cycle.
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        tx_cnt_load = 1'b0;
        tx_cnt_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    tx_sr_d     = tx_data;
                    tx_cnt_load = 1'b1;
                    state_d     = StShift;
                end
            end
            StShift: begin
                // Zero fill leaves the register clear, so tx_so idles low.
                tx_sr_d   = {tx_sr_q[WIDTH-2:0], 1'b0};
                tx_cnt_en = (tx_cnt != '0);
                if (tx_tc) begin
                    state_d = StGap;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        tx_frame_d = (state_d == StShift);
    end

    // RX next-state: assemble words, flag frames that end mid-word.
    always_comb begin
        rx_word    = {rx_sr_q, rx_si};
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        rx_cnt_clr = 1'b0;
        rx_cnt_en  = 1'b0;
        if (rx_frame) begin
            rx_sr_d = rx_word[WIDTH-2:0];
            if (rx_tc) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
                rx_cnt_clr = 1'b1;
            end else begin
                rx_cnt_en = 1'b1;
            end
        end else if (rx_cnt != '0) begin
            rx_cnt_clr = 1'b1;
            rx_err_d   = 1'b1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            tx_sr_q    <= '0;
            tx_frame_q <= 1'b0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            tx_frame_q <= tx_frame_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign tx_ready = (state_q == StIdle);
    assign tx_so    = tx_sr_q[WIDTH-1];
    assign tx_frame = tx_frame_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Self-checking bench for serial_xfer_ctrl: directed scenarios plus randomized
// loopback and raw-RX runs checked against a transaction-level model.
module tb_serial_xfer_ctrl;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_so;
    logic         tx_frame;
    logic         rx_si;
    logic         rx_frame;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_err;

    logic loop;
    logic drv_si;
    logic drv_frame;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic         ready;
        logic         frame;
        logic         so;
        logic         rv;
        logic [W-1:0] rd;
    } exp_t;

    assign rx_si    = loop ? tx_so    : drv_si;
    assign rx_frame = loop ? tx_frame : drv_frame;

    always #5 clk = ~clk;

    serial_xfer_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_so    (tx_so),
        .tx_frame (tx_frame),
        .rx_si    (rx_si),
        .rx_frame (rx_frame),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = '0;
        drv_si    = 1'b0;
        drv_frame = 1'b0;
        loop      = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] got;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            got = {tx_ready, tx_frame, tx_so, rx_valid, rx_err, rx_data};
            checks++;
            if (got !== 9'b1_0_0_0_0_0000) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b expected=%b", i, got, 9'b100000000);
            end
            step();
        end
    endtask

    task automatic test_tx_single();
        logic [W-1:0] word;
        logic [2:0]   got, exp;
        do_reset();
        word     = 4'b1011;
        tx_data  = word;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = W'($urandom);
        for (int k = 0; k < 6; k++) begin
            exp = {(k == 5), (k < 4), (k < 4) ? word[W-1-k] : 1'b0};
            got = {tx_ready, tx_frame, tx_so};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL tx_single k=%0d ready/frame/so got=%b expected=%b", k, got, exp);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [3];
        int           pulses;
        words[0] = 4'hA;
        words[1] = 4'h5;
        words[2] = 4'hF;
        pulses   = 0;
        do_reset();
        loop     = 1'b1;
        tx_data  = words[0];
        tx_valid = 1'b1;
        step();
        for (int c = 1; c <= 18; c++) begin
            checks++;
            if ({rx_valid, rx_err, tx_ready} !== {(c % 6 == 5), 1'b0, (c % 6 == 0)}) begin
                failures++;
                $display("FAIL b2b_timing c=%0d valid/err/ready got=%b%b%b expected=%b0%b",
                         c, rx_valid, rx_err, tx_ready, (c % 6 == 5), (c % 6 == 0));
            end
            if (c % 6 == 5) begin
                pulses++;
                checks++;
                if (rx_data !== words[c / 6]) begin
                    failures++;
                    $display("FAIL b2b_data c=%0d got=%h expected=%h", c, rx_data, words[c / 6]);
                end
            end
            if (c == 1) tx_data = words[1];
            if (c == 7) tx_data = words[2];
            if (c == 13) tx_valid = 1'b0;
            step();
        end
        loop = 1'b0;
    endtask

    task automatic test_rx_err();
        logic [W-1:0] w;
        do_reset();
        w = W'($urandom_range(1, 15));
        for (int i = 0; i < W; i++) begin
            drv_frame = 1'b1;
            drv_si    = w[W-1-i];
            step();
        end
        drv_frame = 1'b0;
        checks++;
        if ({rx_valid, rx_data} !== {1'b1, w}) begin
            failures++;
            $display("FAIL rx_err_setup got valid=%b data=%h expected valid=1 data=%h",
                     rx_valid, rx_data, w);
        end
        drv_frame = 1'b1;
        drv_si    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({rx_valid, rx_err} !== 2'b00) begin
                failures++;
                $display("FAIL rx_err_partial i=%0d valid/err got=%b%b expected=00",
                         i, rx_valid, rx_err);
            end
        end
        drv_frame = 1'b0;
        step();
        checks++;
        if ({rx_valid, rx_err, rx_data} !== {1'b0, 1'b1, w}) begin
            failures++;
            $display("FAIL rx_err_pulse got valid=%b err=%b data=%h expected 0 1 %h",
                     rx_valid, rx_err, rx_data, w);
        end
        step();
        checks++;
        if ({rx_valid, rx_err} !== 2'b00) begin
            failures++;
            $display("FAIL rx_err_one_cycle valid/err got=%b%b expected=00", rx_valid, rx_err);
        end
    endtask

    task automatic test_rx_long();
        logic [7:0]   bits;
        logic [W-1:0] exp_d;
        do_reset();
        bits = 8'b1001_0110;
        for (int i = 0; i < 8; i++) begin
            drv_frame = 1'b1;
            drv_si    = bits[7-i];
            step();
            exp_d = (i >= 7) ? 4'h6 : ((i >= 3) ? 4'h9 : 4'h0);
            checks++;
            if ({rx_valid, rx_err, rx_data} !== {(i == 3 || i == 7), 1'b0, exp_d}) begin
                failures++;
                $display("FAIL rx_long i=%0d got valid=%b err=%b data=%h expected %b 0 %h",
                         i, rx_valid, rx_err, rx_data, (i == 3 || i == 7), exp_d);
            end
        end
        drv_frame = 1'b0;
        step();
        checks++;
        if ({rx_valid, rx_err, rx_data} !== {1'b0, 1'b0, 4'h6}) begin
            failures++;
            $display("FAIL rx_long_end got valid=%b err=%b data=%h expected 0 0 6",
                     rx_valid, rx_err, rx_data);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        loop     = 1'b1;
        tx_data  = 4'hC;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        step();
        checks++;
        if ({tx_frame, tx_so} !== 2'b11) begin
            failures++;
            $display("FAIL reset_mid_pre frame/so got=%b%b expected=11", tx_frame, tx_so);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({tx_frame, tx_ready} !== 2'b01) begin
            failures++;
            $display("FAIL reset_mid_abort frame/ready got=%b%b expected=01", tx_frame, tx_ready);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({tx_ready, tx_frame, rx_valid, rx_err} !== 4'b1000) begin
                failures++;
                $display("FAIL reset_mid_after i=%0d ready/frame/valid/err got=%b%b%b%b expected=1000",
                         i, tx_ready, tx_frame, rx_valid, rx_err);
            end
            step();
        end
        loop = 1'b0;
    endtask

    // Each accepted word expands into WIDTH framed bits then a gap cycle that
    // carries the looped-back word.
    task automatic test_random_loopback();
        exp_t         q[$];
        exp_t         cur;
        exp_t         e;
        logic [W-1:0] w, last_rx, exp_rd;
        logic         accept;
        logic [8:0]   got, exp;
        do_reset();
        loop    = 1'b1;
        last_rx = '0;
        cur     = '{ready: 1'b1, frame: 1'b0, so: 1'b0, rv: 1'b0, rd: '0};
        for (int cyc = 0; cyc < 400; cyc++) begin
            tx_valid = ($urandom_range(0, 2) != 0);
            tx_data  = W'($urandom);
            accept   = tx_valid && cur.ready;
            w        = tx_data;
            step();
            if (accept) begin
                for (int k = 0; k < W; k++) begin
                    e = '{ready: 1'b0, frame: 1'b1, so: w[W-1-k], rv: 1'b0, rd: '0};
                    q.push_back(e);
                end
                e = '{ready: 1'b0, frame: 1'b0, so: 1'b0, rv: 1'b1, rd: w};
                q.push_back(e);
            end
            if (q.size() != 0) cur = q.pop_front();
            else cur = '{ready: 1'b1, frame: 1'b0, so: 1'b0, rv: 1'b0, rd: '0};
            if (cur.rv) last_rx = cur.rd;
            exp_rd = last_rx;
            exp = {cur.ready, cur.frame, cur.so, cur.rv, 1'b0, exp_rd};
            got = {tx_ready, tx_frame, tx_so, rx_valid, rx_err, rx_data};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL rand_loop cyc=%0d ready/frame/so/valid/err/data got=%b expected=%b",
                         cyc, got, exp);
            end
        end
        tx_valid = 1'b0;
        loop     = 1'b0;
    endtask

    task automatic test_random_rx();
        int           acc, n;
        logic [W-1:0] last;
        logic         exp_v, exp_e, f, b;
        do_reset();
        acc  = 0;
        n    = 0;
        last = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            f         = ($urandom_range(0, 3) != 0);
            b         = 1'($urandom);
            drv_frame = f;
            drv_si    = b;
            step();
            exp_v = 1'b0;
            exp_e = 1'b0;
            if (f) begin
                acc = acc * 2 + int'(b);
                n++;
                if (n == W) begin
                    exp_v = 1'b1;
                    last  = acc[W-1:0];
                    acc   = 0;
                    n     = 0;
                end
            end else if (n != 0) begin
                exp_e = 1'b1;
                acc   = 0;
                n     = 0;
            end
            checks++;
            if ({rx_valid, rx_err, rx_data} !== {exp_v, exp_e, last}) begin
                failures++;
                $display("FAIL rand_rx cyc=%0d got valid=%b err=%b data=%h expected %b %b %h",
                         cyc, rx_valid, rx_err, rx_data, exp_v, exp_e, last);
            end
        end
        drv_frame = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_back_to_back();
        test_rx_err();
        test_rx_long();
        test_reset_mid();
        test_random_loopback();
        test_random_rx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
